// File: rtl/octree_pkg.sv
// rtl/octree_pkg.sv - shared octree point packing, depth default and decoder state
package octree_pkg;

  localparam int X_MSB             = 63;
  localparam int Y_MSB             = 47;
  localparam int Z_MSB             = 31;
  localparam int COORD_W           = 16;
  localparam int MAX_DEPTH_DEFAULT = 14;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    CENTER,
    OUT
  } dec_state_t;

  function automatic logic [63:0] pack_point(coord_t x, coord_t y, coord_t z);
    return {x, y, z, {(64 - 3*COORD_W){1'b0}}};
  endfunction

endpackage

// File: rtl/octant_decoder_if.sv
// rtl/octant_decoder_if.sv - request/response bundle of the octant decoder
interface octant_decoder_if #(
  parameter int CODE_W = 42
);
  logic [63:0]       i_near_bottom_left;
  logic [63:0]       i_far_top_right;
  logic [CODE_W-1:0] i_code;
  logic [3:0]        i_code_depth;
  logic              i_valid;
  logic              o_ready;
  logic [63:0]       o_point;
  logic              o_valid;
  logic              i_ready;

  modport master (
    output i_near_bottom_left, i_far_top_right, i_code, i_code_depth, i_valid, i_ready,
    input  o_ready, o_point, o_valid
  );

  modport slave (
    input  i_near_bottom_left, i_far_top_right, i_code, i_code_depth, i_valid, i_ready,
    output o_ready, o_point, o_valid
  );
endinterface

// File: rtl/octant_axis_step.sv
// rtl/octant_axis_step.sv - single-axis halving step: keeps the upper or lower half
module octant_axis_step
  import octree_pkg::*;
(
  input  coord_t cur_min,
  input  coord_t cur_max,
  input  logic   upper,
  output coord_t mid,
  output coord_t new_min,
  output coord_t new_max
);

  // 17-bit sum so the midpoint never overflows; >>> floors toward -inf
  logic signed [COORD_W:0] sum;
  logic signed [COORD_W:0] half;

  assign sum     = {cur_min[COORD_W-1], cur_min} + {cur_max[COORD_W-1], cur_max};
  assign half    = sum >>> 1;
  assign mid     = half[COORD_W-1:0];
  assign new_min = upper ? mid : cur_min;
  assign new_max = upper ? cur_max : mid;

endmodule

// File: rtl/octant_decoder.sv
// rtl/octant_decoder.sv - walks an octant path down a bounding box and emits the voxel centre
module octant_decoder
  import octree_pkg::*;
#(
  parameter int MAX_DEPTH = MAX_DEPTH_DEFAULT,
  parameter int CODE_W    = 3*MAX_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  octant_decoder_if.slave  bus
);

  dec_state_t        state_q, state_d;
  logic [3:0]        lvl_q, depth_q, depth_clamped;
  logic [CODE_W-1:0] code_q;
  coord_t            min_q [3];
  coord_t            max_q [3];
  coord_t            mid_w [3];
  coord_t            nmin_w[3];
  coord_t            nmax_w[3];
  logic [63:0]       point_q;
  logic              accept, last_lvl;
  logic              unused_pad;

  assign bus.o_ready   = i_rst_n && i_en && (state_q == IDLE);
  assign bus.o_valid   = (state_q == OUT);
  assign bus.o_point   = point_q;
  assign accept        = bus.o_ready && bus.i_valid;
  assign depth_clamped = (bus.i_code_depth > 4'(MAX_DEPTH)) ? 4'(MAX_DEPTH) : bus.i_code_depth;
  assign last_lvl      = (lvl_q == depth_q - 4'd1);
  assign unused_pad    = ^{bus.i_near_bottom_left[15:0], bus.i_far_top_right[15:0]};

  // the current level always sits in the top three bits of code_q (x, y, z)
  for (genvar a = 0; a < 3; a++) begin : g_axis
    octant_axis_step u_step (
      .cur_min (min_q[a]),
      .cur_max (max_q[a]),
      .upper   (code_q[CODE_W-1-a]),
      .mid     (mid_w[a]),
      .new_min (nmin_w[a]),
      .new_max (nmax_w[a])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!i_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = (depth_clamped != 4'd0) ? ITER : CENTER;
        ITER:    if (last_lvl) state_d = CENTER;
        CENTER:  state_d = OUT;
        OUT:     if (bus.i_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lvl_q   <= '0;
      depth_q <= '0;
      code_q  <= '0;
      point_q <= '0;
      for (int a = 0; a < 3; a++) begin
        min_q[a] <= '0;
        max_q[a] <= '0;
      end
    end else if (i_en) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            depth_q  <= depth_clamped;
            code_q   <= bus.i_code;
            lvl_q    <= '0;
            min_q[0] <= bus.i_near_bottom_left[X_MSB -: COORD_W];
            min_q[1] <= bus.i_near_bottom_left[Y_MSB -: COORD_W];
            min_q[2] <= bus.i_near_bottom_left[Z_MSB -: COORD_W];
            max_q[0] <= bus.i_far_top_right[X_MSB -: COORD_W];
            max_q[1] <= bus.i_far_top_right[Y_MSB -: COORD_W];
            max_q[2] <= bus.i_far_top_right[Z_MSB -: COORD_W];
          end
        end
        ITER: begin
          min_q  <= nmin_w;
          max_q  <= nmax_w;
          code_q <= code_q << 3;
          lvl_q  <= last_lvl ? 4'd0 : lvl_q + 4'd1;
        end
        CENTER:  point_q <= pack_point(mid_w[0], mid_w[1], mid_w[2]);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_octant_decoder.sv
// tb/tb_octant_decoder.sv - directed and model-checked bench for octant_decoder
module tb_octant_decoder;
  import octree_pkg::*;

  localparam int MAX_DEPTH = 14;
  localparam int CODE_W    = 3*MAX_DEPTH;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  int   vectors     = 0;
  int   miscompares = 0;
  logic        lit_en;
  logic [63:0] lit_val;

  always #5 clk = ~clk;

  octant_decoder_if #(.CODE_W(CODE_W)) bus ();

  octant_decoder #(.MAX_DEPTH(MAX_DEPTH), .CODE_W(CODE_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .bus     (bus)
  );

  function automatic int clampd(int d);
    return (d > MAX_DEPTH) ? MAX_DEPTH : d;
  endfunction

  // centre of the voxel reached by following the code, computed with plain integers
  function automatic logic [63:0] model_point(logic [63:0] bl, logic [63:0] tr,
                                              logic [CODE_W-1:0] code, int depth);
    logic [63:0]       r;
    logic [CODE_W-1:0] sh;
    logic [2:0]        bits;
    int lo, hi, mid, d;
    r = '0;
    d = clampd(depth);
    for (int a = 0; a < 3; a++) begin
      lo = int'($signed(bl[63-16*a -: 16]));
      hi = int'($signed(tr[63-16*a -: 16]));
      for (int n = 1; n <= d; n++) begin
        sh   = code >> (CODE_W - 3*n);
        bits = sh[2:0];
        mid  = (lo + hi) >>> 1;
        if (bits[2-a]) lo = mid;
        else           hi = mid;
      end
      r[63-16*a -: 16] = 16'((lo + hi) >>> 1);
    end
    return r;
  endfunction

  function automatic logic [63:0] pk(int x, int y, int z);
    return {16'(x), 16'(y), 16'(z), 16'h0000};
  endfunction

  function automatic logic [63:0] bx(int x, int y, int z);
    return {16'(x), 16'(y), 16'(z), 16'hBEEF};
  endfunction

  // transaction-level model: accept when free, output after depth+2 edges, hold until taken
  logic        m_busy, m_valid;
  int          m_cnt;
  logic [63:0] m_point, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0; m_point <= '0; m_pend <= '0;
    end else if (!en) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
    end else if (!m_busy) begin
      if (bus.i_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= clampd(int'(bus.i_code_depth)) + 1;
        m_pend <= model_point(bus.i_near_bottom_left, bus.i_far_top_right,
                              bus.i_code, int'(bus.i_code_depth));
      end
    end else if (m_valid) begin
      if (bus.i_ready) begin
        m_busy <= 1'b0; m_valid <= 1'b0;
      end
    end else if (m_cnt == 1) begin
      m_valid <= 1'b1; m_point <= m_pend; m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    logic exp_ready;
    exp_ready = !m_busy && en && rst_n;
    chk("o_valid", {63'h0, bus.o_valid}, {63'h0, m_valid});
    chk("o_ready", {63'h0, bus.o_ready}, {63'h0, exp_ready});
    chk("o_point", bus.o_point, m_point);
    if (lit_en && bus.o_valid) chk("literal point", bus.o_point, lit_val);
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input logic [63:0] bl, input logic [63:0] tr, input logic [CODE_W-1:0] code,
                     input logic [3:0] dep, input int hold, input logic use_lit,
                     input logic [63:0] lit);
    int n;
    lit_en = use_lit; lit_val = lit;
    bus.i_near_bottom_left = bl; bus.i_far_top_right = tr;
    bus.i_code = code; bus.i_code_depth = dep; bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    bus.i_near_bottom_left = {$urandom, $urandom};
    bus.i_far_top_right    = {$urandom, $urandom};
    bus.i_code = ~code; bus.i_code_depth = ~dep;
    n = 0;
    while (!bus.o_valid && n < 24) begin
      tick();
      n++;
    end
    if (!bus.o_valid) begin
      vectors++; miscompares++;
      $display("FAIL timeout waiting for o_valid at %0t", $time);
    end
    chk("latency", 64'(n), 64'(clampd(int'(dep)) + 1));
    repeat (hold) tick();
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    lit_en = 1'b0;
    tick();
  endtask

  task automatic abort(input logic use_reset);
    bus.i_near_bottom_left = bx(-25600, -25600, -25600);
    bus.i_far_top_right    = bx(25600, 25600, 25600);
    bus.i_code = CODE_W'({$urandom, $urandom}); bus.i_code_depth = 4'd14; bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    repeat (3) tick();
    if (use_reset) rst_n = 1'b0;
    else           en = 1'b0;
    tick(); tick();
    rst_n = 1'b1; en = 1'b1;
    repeat (20) tick();
  endtask

  logic [63:0]       lo_box, hi_box;
  logic [CODE_W-1:0] c;

  initial begin
    rst_n = 1'b1; en = 1'b1; lit_en = 1'b0; lit_val = '0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_code = '0; bus.i_code_depth = '0;
    bus.i_near_bottom_left = '0; bus.i_far_top_right = '0;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("reset o_point", bus.o_point, 64'h0);
    chk("reset o_ready", {63'h0, bus.o_ready}, 64'h0);
    rst_n = 1'b1;
    tick();
    chk("idle o_ready", {63'h0, bus.o_ready}, 64'h1);

    lo_box = bx(-25600, -25600, -25600);
    hi_box = bx(25600, 25600, 25600);

    c = CODE_W'({$urandom, $urandom}); c[CODE_W-1 -: 3] = 3'b111;
    run(lo_box, hi_box, c, 4'd1, 0, 1'b1, pk(12800, 12800, 12800));
    c = CODE_W'({$urandom, $urandom});
    run(lo_box, hi_box, c, 4'd0, 1, 1'b1, pk(0, 0, 0));
    run(bx(-3, -25600, -25600), bx(4, 25600, 25600), c, 4'd0, 0, 1'b1, pk(0, 0, 0));
    run(bx(-4, -25600, -25600), bx(3, 25600, 25600), c, 4'd0, 0, 1'b1, pk(-1, 0, 0));
    c = CODE_W'({$urandom, $urandom}); c[CODE_W-1 -: 6] = 6'b000000;
    run(lo_box, hi_box, c, 4'd2, 0, 1'b1, pk(-19200, -19200, -19200));
    c = CODE_W'({$urandom, $urandom}); c[CODE_W-1 -: 3] = 3'b100;
    run(lo_box, hi_box, c, 4'd1, 5, 1'b1, pk(12800, -12800, -12800));
    c = '1;
    run(lo_box, hi_box, c, 4'd14, 0, 1'b1, pk(25598, 25598, 25598));
    run(lo_box, hi_box, c, 4'd15, 2, 1'b1, pk(25598, 25598, 25598));

    abort(1'b1);
    c = CODE_W'({$urandom, $urandom}); c[CODE_W-1 -: 3] = 3'b100;
    run(lo_box, hi_box, c, 4'd1, 0, 1'b1, pk(12800, -12800, -12800));
    abort(1'b0);
    c = CODE_W'({$urandom, $urandom}); c[CODE_W-1 -: 6] = 6'b000000;
    run(lo_box, hi_box, c, 4'd2, 0, 1'b1, pk(-19200, -19200, -19200));

    en = 1'b0; bus.i_valid = 1'b1;
    repeat (3) tick();
    bus.i_valid = 1'b0; en = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run({$urandom, $urandom}, {$urandom, $urandom}, CODE_W'({$urandom, $urandom}),
          4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b0, 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
